clk_rst_sequencer: RTL and testbench

CLK_RST_SEQUENCER -- requirements
Module: clk_rst_sequencer

---
 rtl/clk_rst_param_pkg.sv | 36 +++
 rtl/clk_rst_sync.sv | 25 ++
 rtl/clk_rst_sequencer.sv | 152 +++++++++++++++
 tb/tb_clk_rst_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_param_pkg.sv
// Purpose : shared state encoding, parameter defaults and counter sizing for the reset sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package clk_rst_param_pkg;

    localparam int DEF_FANOUT         = 4;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_HOLD_CYCLES    = 16;
    localparam int DEF_STAGGER_CYCLES = 4;
    localparam int DEF_QUIESCE_CYCLES = 2;

    // Encodings are visible on state_o, so they are pinned explicitly.
    typedef enum logic [2:0] {
        ST_ASSERT  = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_QUIESCE = 3'd4
    } seq_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // One counter serves HOLD, RELEASE and QUIESCE; it must hold the largest
    // terminal count of any of them without wrapping.
    function automatic int cnt_width(input int hold, input int fanout,
                                     input int stagger, input int quiesce);
        return $clog2(max3(hold, fanout * stagger, quiesce) + 1);
    endfunction

endpackage

// File: rtl/clk_rst_sync.sv
// Purpose : reset synchronizer, asynchronous assert, STAGES-flop synchronous deassert.
// Latency : deassert visible STAGES rising edges after rst_n_i goes high; assert immediate.
// Backpressure: none.
// Ports   : clk (clock), rst_n_i (raw async active-low reset), rst_n_o (synchronized reset).
module clk_rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n_i,
    output logic rst_n_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign rst_n_o = sync_q[STAGES-1];

endmodule

// File: rtl/clk_rst_sequencer.sv
// Purpose : per-channel reset/clock-enable sequencer (power-on and software-triggered sequences).
// Latency : all outputs registered; boot reaches RUN HOLD_CYCLES+(FANOUT-1)*STAGGER_CYCLES+2 cycles after sync reset release.
// Backpressure: none; sw_rst_req/ch_mask are sampled only in RUN and ignored elsewhere.
// Ports   : clk, reset_n (async active-low), sw_rst_req (level), ch_mask (1 = excluded),
//           rst_n_out / clk_en_out (per channel), busy (not RUN), seq_done (RUN entry pulse), state_o (debug).
module clk_rst_sequencer
    import clk_rst_param_pkg::*;
#(
    parameter int FANOUT         = DEF_FANOUT,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
    parameter int QUIESCE_CYCLES = DEF_QUIESCE_CYCLES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sw_rst_req,
    input  logic [FANOUT-1:0] ch_mask,
    output logic [FANOUT-1:0] rst_n_out,
    output logic [FANOUT-1:0] clk_en_out,
    output logic              busy,
    output logic              seq_done,
    output logic [2:0]        state_o
);

    if (FANOUT < 1 || FANOUT > 32) begin : g_bad_fanout
        $error("clk_rst_sequencer: FANOUT must be 1..32");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("clk_rst_sequencer: SYNC_STAGES must be >= 2");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("clk_rst_sequencer: HOLD_CYCLES must be >= 1");
    end
    if (STAGGER_CYCLES < 1) begin : g_bad_stagger
        $error("clk_rst_sequencer: STAGGER_CYCLES must be >= 1");
    end
    if (QUIESCE_CYCLES < 1) begin : g_bad_quiesce
        $error("clk_rst_sequencer: QUIESCE_CYCLES must be >= 1");
    end

    localparam int CNT_W = cnt_width(HOLD_CYCLES, FANOUT, STAGGER_CYCLES, QUIESCE_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'((FANOUT - 1) * STAGGER_CYCLES);
    localparam logic [CNT_W-1:0] QUI_LAST  = CNT_W'(QUIESCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic              rst_sync_n;
    seq_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [FANOUT-1:0] aff_q;
    logic [FANOUT-1:0] rst_n_q;
    logic [FANOUT-1:0] clk_en_q;
    logic              busy_q;
    logic              done_q;
    logic [FANOUT-1:0] slot_hit;

    clk_rst_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n_i (reset_n),
        .rst_n_o (rst_sync_n)
    );

    // In RELEASE cnt_q is the offset of the current cycle from RELEASE entry.
    // A channel whose slot equals the next offset is released on this edge,
    // so its registered rst_n_out rises exactly at offset i*STAGGER_CYCLES.
    // Slot 0 is offset 0 and is therefore released on the HOLD exit edge.
    always_comb begin
        slot_hit = '0;
        for (int i = 1; i < FANOUT; i++) begin
            if (int'(cnt_q) + 1 == i * STAGGER_CYCLES) begin
                slot_hit[i] = 1'b1;
            end
        end
    end

    // Masked channels already sit at rst_n=1/clk_en=1, so setting bits via OR
    // in RELEASE leaves them untouched while keeping the slot timing fixed.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q  <= ST_ASSERT;
            cnt_q    <= '0;
            aff_q    <= '0;
            rst_n_q  <= '0;
            clk_en_q <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_ASSERT: begin
                    aff_q    <= '1;
                    clk_en_q <= '1;
                    cnt_q    <= '0;
                    state_q  <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q      <= '0;
                        rst_n_q[0] <= 1'b1;
                        state_q    <= ST_RELEASE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    rst_n_q <= rst_n_q | slot_hit;
                    if (cnt_q == REL_LAST) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    // An all-ones mask selects nothing, so the request is dropped.
                    if (sw_rst_req && ((~ch_mask) != '0)) begin
                        aff_q    <= ~ch_mask;
                        clk_en_q <= ch_mask;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_QUIESCE;
                    end
                end
                ST_QUIESCE: begin
                    if (cnt_q == QUI_LAST) begin
                        rst_n_q  <= ~aff_q;
                        clk_en_q <= '1;
                        cnt_q    <= '0;
                        state_q  <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_ASSERT;
                end
            endcase
        end
    end

    assign rst_n_out  = rst_n_q;
    assign clk_en_out = clk_en_q;
    assign busy       = busy_q;
    assign seq_done   = done_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
module tb_clk_rst_sequencer;

    localparam int F    = 4;
    localparam int SYNC = 2;
    localparam int H    = 16;
    localparam int S    = 4;
    localparam int Q    = 2;

    localparam logic [2:0] E_ASSERT  = 3'd0;
    localparam logic [2:0] E_HOLD    = 3'd1;
    localparam logic [2:0] E_RELEASE = 3'd2;
    localparam logic [2:0] E_RUN     = 3'd3;
    localparam logic [2:0] E_QUIESCE = 3'd4;

    localparam int K_RST  = 0;
    localparam int K_BOOT = 1;
    localparam int K_SW   = 2;
    localparam int K_RUN  = 3;

    logic         clk        = 1'b0;
    logic         reset_n    = 1'b1;
    logic         sw_rst_req = 1'b0;
    logic [F-1:0] ch_mask    = '0;
    logic [F-1:0] rst_n_out;
    logic [F-1:0] clk_en_out;
    logic         busy;
    logic         seq_done;
    logic [2:0]   state_o;

    int total = 0;
    int bad   = 0;

    clk_rst_sequencer #(
        .FANOUT         (F),
        .SYNC_STAGES    (SYNC),
        .HOLD_CYCLES    (H),
        .STAGGER_CYCLES (S),
        .QUIESCE_CYCLES (Q)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sw_rst_req (sw_rst_req),
        .ch_mask    (ch_mask),
        .rst_n_out  (rst_n_out),
        .clk_en_out (clk_en_out),
        .busy       (busy),
        .seq_done   (seq_done),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A sequence is described by its kind and the cycle offset t since it
    // began; every output is a pure function of (kind, t, affected set).
    int           m_kind = K_RST;
    int           m_t    = 0;
    int           m_hi   = 0;
    logic [F-1:0] m_aff  = '0;
    bit           m_done = 1'b0;

    function automatic int prelude(input int kind);
        return (kind == K_BOOT) ? 1 : Q;
    endfunction

    task automatic model_step();
        m_done = 1'b0;
        if (!reset_n) begin
            m_kind = K_RST;
            m_hi   = 0;
        end else begin
            case (m_kind)
                K_RST: begin
                    if (m_hi < SYNC) m_hi++;
                    if (m_hi == SYNC) begin
                        m_kind = K_BOOT;
                        m_t    = 0;
                        m_aff  = '1;
                    end
                end
                K_BOOT, K_SW: begin
                    m_t++;
                    if (m_t == prelude(m_kind) + H + (F - 1) * S + 1) begin
                        m_kind = K_RUN;
                        m_done = 1'b1;
                    end
                end
                default: begin
                    if (sw_rst_req && ((~ch_mask) != '0)) begin
                        m_kind = K_SW;
                        m_t    = 0;
                        m_aff  = ~ch_mask;
                    end
                end
            endcase
        end
    endtask

    function automatic logic [2*F+4:0] model_out();
        logic [F-1:0] r;
        logic [F-1:0] c;
        logic         b;
        logic         d;
        logic [2:0]   st;
        int           p;
        r = '0; c = '0; b = 1'b1; d = 1'b0; st = E_ASSERT;
        if (m_kind == K_RUN) begin
            r = '1; c = '1; b = 1'b0; d = m_done; st = E_RUN;
        end else if (m_kind != K_RST) begin
            p = prelude(m_kind);
            if (m_t < p)          st = (m_kind == K_BOOT) ? E_ASSERT : E_QUIESCE;
            else if (m_t < p + H) st = E_HOLD;
            else                  st = E_RELEASE;
            for (int i = 0; i < F; i++) begin
                if (!m_aff[i]) begin
                    r[i] = 1'b1; c[i] = 1'b1;
                end else if (m_t < p) begin
                    r[i] = (m_kind == K_SW); c[i] = 1'b0;
                end else if (m_t < p + H) begin
                    r[i] = 1'b0; c[i] = 1'b1;
                end else begin
                    r[i] = (m_t >= p + H + i * S); c[i] = 1'b1;
                end
            end
        end
        return {r, c, b, d, st};
    endfunction

    // ---------------- per-cycle compare ----------------
    initial begin : monitor
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check("cycle", {rst_n_out, clk_en_out, busy, seq_done, state_o}, model_out());
            if (reset_n) check("rst_x", $isunknown(rst_n_out), 0);
            if (seq_done === 1'b1) check("done_twice", prev_done, 0);
            prev_done = seq_done;
        end
    end

    // ---------------- directed observation helpers ----------------
    int ob_rise[F];
    int ob_rst_lo[F];
    int ob_ce_lo[F];
    int ob_done_n;
    int ob_done_at;
    int ob_free_at;
    int ob_busy_n;

    task automatic observe(input int n, input int drop_at);
        for (int i = 0; i < F; i++) begin
            ob_rise[i] = -1; ob_rst_lo[i] = 0; ob_ce_lo[i] = 0;
        end
        ob_done_n = 0; ob_done_at = -1; ob_free_at = -1; ob_busy_n = 0;
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < F; i++) begin
                if (rst_n_out[i] === 1'b1 && ob_rise[i] < 0) ob_rise[i] = e;
                if (rst_n_out[i] !== 1'b1) ob_rst_lo[i]++;
                if (clk_en_out[i] !== 1'b1) ob_ce_lo[i]++;
            end
            if (seq_done === 1'b1) begin
                ob_done_n++;
                if (ob_done_at < 0) ob_done_at = e;
            end
            if (busy === 1'b1) ob_busy_n++;
            if (busy === 1'b0 && ob_free_at < 0) ob_free_at = e;
            if (e == drop_at) sw_rst_req = 1'b0;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rst_n"},  rst_n_out, 0);
        check({tag, "_clk_en"}, clk_en_out, 0);
        check({tag, "_busy"},   busy, 1);
        check({tag, "_done"},   seq_done, 0);
        check({tag, "_state"},  state_o, 0);
    endtask

    // Boot cycle numbers: cycle 0 is SYNC edges after reset_n rises.
    task automatic check_boot(input string tag);
        int exp_rise[F] = '{17, 21, 25, 29};
        for (int i = 0; i < F; i++) check({tag, "_rise"}, ob_rise[i] - SYNC, exp_rise[i]);
        check({tag, "_done_at"}, ob_done_at - SYNC, 30);
        check({tag, "_free_at"}, ob_free_at - SYNC, 30);
        check({tag, "_done_n"},  ob_done_n, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals("por");

        // cold boot
        @(negedge clk); reset_n = 1'b1;
        observe(40, 0);
        check_boot("boot");

        // software reset of channels 1 and 3
        @(negedge clk); ch_mask = 4'b0101; sw_rst_req = 1'b1;
        observe(40, 1);
        check("sw_ce_lo0",  ob_ce_lo[0], 0);
        check("sw_ce_lo1",  ob_ce_lo[1], 2);
        check("sw_ce_lo2",  ob_ce_lo[2], 0);
        check("sw_ce_lo3",  ob_ce_lo[3], 2);
        check("sw_rst_lo0", ob_rst_lo[0], 0);
        check("sw_rst_lo1", ob_rst_lo[1], 20);
        check("sw_rst_lo2", ob_rst_lo[2], 0);
        check("sw_rst_lo3", ob_rst_lo[3], 28);
        check("sw_done_at", ob_done_at, 32);
        check("sw_done_n",  ob_done_n, 1);

        // all-masked request is ignored
        @(negedge clk); ch_mask = 4'b1111; sw_rst_req = 1'b1;
        observe(12, 12);
        check("mask_busy_n", ob_busy_n, 0);
        check("mask_done_n", ob_done_n, 0);
        check("mask_state",  state_o, E_RUN);

        // reset pulse during RELEASE after channel 1 released
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); @(negedge clk); reset_n = 1'b1;
        observe(25, 0);
        check("mid_rise0", ob_rise[0] - SYNC, 17);
        check("mid_rise1", ob_rise[1] - SYNC, 21);
        check("mid_rise2", ob_rise[2], -1);
        @(negedge clk); reset_n = 1'b0;
        #1;
        check_reset_vals("mid");
        @(negedge clk); reset_n = 1'b1;
        observe(40, 0);
        check_boot("reboot");

        // request raised in boot HOLD and held into RUN
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        observe(7, 0);
        check("early_state", state_o, E_HOLD);
        ch_mask = 4'b1101; sw_rst_req = 1'b1;
        observe(60, 26);
        check("early_done_n", ob_done_n, 2);
        check("early_ce_lo0", ob_ce_lo[0], 0);
        check("early_ce_lo1", ob_ce_lo[1], 2);
        check("early_ce_lo3", ob_ce_lo[3], 0);
        check("early_rst_lo0", ob_rst_lo[0], 11);
        check("early_rst_lo1", ob_rst_lo[1], 35);

        // randomized traffic, checked cycle by cycle against the model
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            reset_n    = ($urandom_range(0, 399) != 0);
            sw_rst_req = ($urandom_range(0, 5) == 0);
            ch_mask    = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom);
        end
        @(negedge clk); reset_n = 1'b1; sw_rst_req = 1'b0;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
